// File: rtl/booth_mul_arbiter.sv
// rtl/booth_mul_arbiter.sv - round-robin arbiter sharing one sequential signed multiplier
//
// Purpose: arbitrates N_REQ requesters onto a single multiplier driven by a
// start/done handshake, and returns each product tagged with its requester.
// Optional macro MUL_TIMEOUT_EN: abort a multiply that has not finished
// TIMEOUT cycles after start and answer with rsp_err=1, rsp_data=0.
//
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   req                   per-requester level request
//   a_in, b_in            packed operands, slice i belongs to requester i
//   gnt                   one-hot one-cycle grant pulse
//   rsp_valid/id/data/err registered response (err only meaningful with valid)
//   mul_start/a/b         start pulse and held operands to the multiplier
//   mul_done/product      completion and result from the multiplier

module booth_mul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*WIDTH-1:0]     a_in,
  input  logic [N_REQ*WIDTH-1:0]     b_in,
  output logic [N_REQ-1:0]           gnt,
  output logic                       rsp_valid,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [2*WIDTH-1:0]         rsp_data,
  output logic                       rsp_err,
  output logic                       mul_start,
  output logic [WIDTH-1:0]           mul_a,
  output logic [WIDTH-1:0]           mul_b,
  input  logic                       mul_done,
  input  logic [2*WIDTH-1:0]         mul_product
);

  localparam int IDW = $clog2(N_REQ);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("booth_mul_arbiter: N_REQ must be in 2..8");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("booth_mul_arbiter: TIMEOUT must be at least 2");
  end

  logic [1:0]           state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [IDW-1:0]       owner_q, owner_d;
  logic [N_REQ-1:0]     gnt_q, gnt_d;
  logic                 mul_start_q, mul_start_d;
  logic [WIDTH-1:0]     mul_a_q, mul_a_d;
  logic [WIDTH-1:0]     mul_b_q, mul_b_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]       rsp_id_q, rsp_id_d;
  logic [2*WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;

  logic                 found;
  logic [IDW-1:0]       winner;
  logic [IDW-1:0]       idx;

`ifdef MUL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]        cnt_q, cnt_d;
`endif

  // Round-robin scan starting at ptr_q; the first asserted request wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = IDW'((int'(ptr_q) + i) % N_REQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    gnt_d       = '0;
    mul_start_d = 1'b0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
`ifdef MUL_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d[winner] = 1'b1;
          owner_d       = winner;
          mul_a_d       = a_in[int'(winner)*WIDTH +: WIDTH];
          mul_b_d       = b_in[int'(winner)*WIDTH +: WIDTH];
          mul_start_d   = 1'b1;
          state_d       = S_BUSY;
`ifdef MUL_TIMEOUT_EN
          cnt_d         = '0;
`endif
        end
      end
      S_BUSY: begin
`ifdef MUL_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        // A done coincident with our own start pulse belongs to nothing we issued.
        if (!mul_start_q && mul_done) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = owner_q;
          rsp_data_d  = mul_product;
          rsp_err_d   = 1'b0;
          state_d     = S_RESP;
        end
`ifdef MUL_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = owner_q;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          state_d     = S_RESP;
        end
`endif
      end
      S_RESP: begin
        ptr_d   = (owner_q == IDW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      gnt_q       <= '0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
`ifdef MUL_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      mul_start_q <= mul_start_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
`ifdef MUL_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/booth_mul_arbiter.md
Name: booth_mul_arbiter

Overview:
Shares one sequential signed (Booth) multiplier datapath+controller pair between N_REQ requesters. Round-robin arbitration picks one requester, latches its operands, pulses start to the multiplier, waits for done, then returns the product tagged with the requester index. Sits between client blocks and the multiplier; the multiplier is driven only through a start/done handshake.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 5, operand width in bits, signed two's complement; product is 2*WIDTH bits
TIMEOUT, 64, cycles allowed from start to done (used only with MUL_TIMEOUT_EN)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
req  input  N_REQ  per-requester request, level
a_in  input  N_REQ*WIDTH  multiplicands, slice i = requester i
b_in  input  N_REQ*WIDTH  multipliers, slice i = requester i
gnt  output  N_REQ  one-hot grant pulse
rsp_valid  output  1  result pulse
rsp_id  output  $clog2(N_REQ)  index of requester owning the result
rsp_data  output  2*WIDTH  signed product
rsp_err  output  1  timeout flag, qualified by rsp_valid
mul_start  output  1  start pulse to multiplier
mul_a  output  WIDTH  operand A to multiplier, held stable during BUSY
mul_b  output  WIDTH  operand B to multiplier, held stable during BUSY
mul_done  input  1  multiplier completion
mul_product  input  2*WIDTH  multiplier result, valid while mul_done high

Behaviour:
- All outputs registered. On rst (any time, async): state=IDLE, ptr=0, owner=0, gnt=0, mul_start=0, mul_a=0, mul_b=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0. In-flight operation is discarded; no response is issued for it.
- FSM states: IDLE, BUSY, RESP.
- IDLE: at an edge with req!=0, winner = first asserted req scanning ptr, ptr+1, ... wrapping mod N_REQ. At that edge: gnt<=onehot(winner), owner<=winner, mul_a/mul_b<=winner's slices, mul_start<=1, state<=BUSY. With req==0, stay in IDLE.
- BUSY: gnt<=0, mul_start<=0 after the first cycle (both are exactly one-cycle pulses). mul_done is ignored while mul_start is high. On the first edge with mul_done=1: rsp_data<=mul_product, rsp_id<=owner, rsp_err<=0, rsp_valid<=1, state<=RESP.
- RESP: rsp_valid<=0, ptr<=(owner+1) mod N_REQ, state<=IDLE. rsp_data and rsp_id hold their values until the next response.
- Latency: gnt is high in the cycle after req is first sampled in IDLE. rsp_valid goes high one cycle after the mul_done edge. Minimum back-to-back spacing is 3 cycles plus multiplier latency.
- req is sampled only in IDLE. A requester deasserts req in the cycle it sees gnt. If req is still high at the next IDLE, it is a new request.
- mul_done seen in IDLE or RESP is ignored.
- Arithmetic: product is the full 2*WIDTH signed result from the multiplier. The arbiter performs no arithmetic on it.

Optional Feature:
MUL_TIMEOUT_EN. When defined, a counter clears on mul_start and increments each BUSY cycle. If it reaches TIMEOUT with no mul_done, the block issues rsp_valid=1, rsp_err=1, rsp_data=0, rsp_id=owner, then enters RESP (ptr advances normally). A mul_done arriving later is ignored. When not defined, there is no counter, rsp_err is constant 0, and BUSY waits indefinitely.

Test Plan:
- Reset, then req=4'b0010, a1=-10, b1=13; behavioural multiplier with 6-cycle latency -> gnt=0010 for one cycle, mul_start one pulse, mul_a=5'h16, mul_b=5'h0D, then rsp_valid pulse with rsp_id=1, rsp_data=10'h37E (-130).
- Reset, then req=0101 held after each grant -> grant order 0, 2, 0, 2. rsp_id matches each grant, with a1*b1 products checked.
- All four req held continuously -> grants rotate 0,1,2,3,0. No requester is granted twice before all others.
- Assert rst three cycles into BUSY -> all outputs 0 the same cycle (async). No rsp_valid for that operation. The next request is arbitrated from ptr=0.
- mul_done pulsed while IDLE with req=0 -> no rsp_valid, state stays IDLE. Operands a=-16, b=-16 -> rsp_data=10'h100 (+256).
- With MUL_TIMEOUT_EN, TIMEOUT=8, multiplier never asserts done -> rsp_valid=1, rsp_err=1, rsp_data=0 eight cycles after start. A late done is ignored. Without the macro, the same stimulus stays in BUSY.
